// File: rtl/up5bit_counter_sched.sv
// Round-robin scheduler sharing one 5-bit up-counter among NREQ requesters.
// Define UP5_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module up5bit_counter_sched #(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [4:0]        cnt,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req[i] high from request until the cycle
  // after its done[i] pulse; dropping req[owner] during COUNT aborts the
  // window. gnt/done/cnt/owner/busy are all flop outputs.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        len_q, len_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic              busy_q, busy_d;

  logic              win_found;
  logic [OW-1:0]     win_idx;

  // Search from ptr+1 upward with wrap; iterating backwards lets the
  // nearest set bit overwrite farther ones.
  always_comb begin
    int tmp;
    win_found = 1'b0;
    win_idx   = '0;
    tmp       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      tmp = int'(ptr_q) + k;
      if (tmp >= NREQ) tmp = tmp - NREQ;
      if (req[tmp]) begin
        win_found = 1'b1;
        win_idx   = OW'(tmp);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_COUNT;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          ptr_d            = win_idx;
          len_d            = len[5*win_idx +: 5];
          cnt_d            = 5'd0;
        end
      end
      ST_COUNT: begin
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = 5'd0;
        end else if (cnt_q == len_q) begin
          state_d          = ST_DONE;
          done_d[owner_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = 5'd0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = 5'd0;
      end
    endcase

`ifdef UP5_SCHED_FIXED_PRIO_EN
    // Pointer pinned at NREQ-1 so every search begins at index 0.
    ptr_d = OW'(NREQ - 1);
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= 5'd0;
      len_q   <= 5'd0;
      owner_q <= '0;
      ptr_q   <= OW'(NREQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign cnt       = cnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_up5bit_counter_sched.sv
// Directed bench for up5bit_counter_sched (NREQ=4); expectations are hand-derived.
module tb_up5bit_counter_sched;

  localparam int NREQ = 4;
  localparam int OW   = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] len;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [4:0]        cnt;
  logic [OW-1:0]     owner;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_vec;
  int n_err;

  up5bit_counter_sched #(.NREQ(NREQ), .OW(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .gnt       (gnt),
    .done      (done),
    .cnt       (cnt),
    .owner     (owner),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int egnt, input int edone,
                           input int ecnt, input int eown, input int ebusy);
    check({tag, "_gnt"},   32'(gnt),   32'(egnt));
    check({tag, "_done"},  32'(done),  32'(edone));
    check({tag, "_cnt"},   32'(cnt),   32'(ecnt));
    check({tag, "_owner"}, 32'(owner), 32'(eown));
    check({tag, "_busy"},  32'(busy),  32'(ebusy));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    len[5*i +: 5] = 5'(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    len   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int w;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    req   = '0;
    len   = '0;

    // reset state
    #2;
    do_reset();
    check_all("rst", 0, 0, 0, 0, 0);

    // single window, len0=3
    req = 4'b0001;
    set_len(0, 3);
    tick(); check_all("t1_grant", 1, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      tick(); check("t1_cnt", 32'(cnt), 32'(i));
    end
    tick(); check_all("t1_done", 1, 1, 3, 0, 1);
    req = '0;
    tick(); check_all("t1_idle", 0, 0, 0, 0, 0);

    // all four requesting, len=0: grants 0,1,2,3,0 three cycles apart
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef UP5_SCHED_FIXED_PRIO_EN
      w = 0;
`else
      w = g % 4;
`endif
      tick(); check_all("t2_grant", 1 << w, 0, 0, w, 1);
      tick(); check_all("t2_done", 1 << w, 1 << w, 0, w, 1);
      if (g == 4) req = '0;
      tick(); check_all("t2_idle", 0, 0, 0, w, 0);
    end
    tick(); check_all("t2_quiet", 0, 0, 0, w, 0);

    // len2=31: no wrap, done 32 edges after grant
    req = 4'b0100;
    set_len(2, 31);
    tick(); check_all("t3_grant", 4, 0, 0, 2, 1);
    for (int i = 1; i <= 31; i++) begin
      tick(); check("t3_cnt", 32'(cnt), 32'(i));
    end
    tick(); check_all("t3_done", 4, 4, 31, 2, 1);
    req = '0;
    tick(); check_all("t3_idle", 0, 0, 0, 2, 0);

    // abort by owner 1, pending req3 granted afterwards
    do_reset();
    req = 4'b1010;
    set_len(1, 10);
    set_len(3, 2);
    tick(); check_all("t4_grant1", 2, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      tick(); check("t4_cnt", 32'(cnt), 32'(i));
    end
    req = 4'b1000;
    tick(); check_all("t4_abort", 0, 0, 0, 1, 0);
    tick(); check_all("t4_grant3", 8, 0, 0, 3, 1);
    tick(); check("t4_cnt3", 32'(cnt), 32'd1);
    tick(); check_all("t4_last", 8, 0, 2, 3, 1);
    tick(); check_all("t4_done", 8, 8, 2, 3, 1);
    req = '0;
    tick(); check_all("t4_idle", 0, 0, 0, 3, 0);

    // asynchronous reset mid-window at cnt=7
    req = 4'b0001;
    set_len(0, 20);
    tick(); check_all("t5_grant", 1, 0, 0, 0, 1);
    repeat (7) tick();
    check("t5_cnt7", 32'(cnt), 32'd7);
    #2;
    reset = 1'b0;
    #1;
    check_all("t5_async", 0, 0, 0, 0, 0);
    req = '0;
    tick();
    tick(); check_all("t5_held", 0, 0, 0, 0, 0);
    reset = 1'b1;
    req = 4'b1010;
    tick(); check_all("t5_regrant", 2, 0, 0, 1, 1);
    req = '0;
    tick(); check_all("t5_abort", 0, 0, 0, 1, 0);

    // len changes after grant are ignored
    do_reset();
    req = 4'b0001;
    set_len(0, 5);
    tick(); check_all("t6_grant", 1, 0, 0, 0, 1);
    tick(); check("t6_cnt1", 32'(cnt), 32'd1);
    set_len(0, 2);
    tick(); check_all("t6_cnt2", 1, 0, 2, 0, 1);
    tick();
    tick();
    tick(); check_all("t6_cnt5", 1, 0, 5, 0, 1);
    tick(); check_all("t6_done", 1, 1, 5, 0, 1);
    req = '0;
    tick(); check_all("t6_idle", 0, 0, 0, 0, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/up5bit_counter_sched.md
# up5bit_counter_sched

Round-robin scheduler that shares one 5-bit up-counter among `NREQ` requesters. Each requester asks for a timed window of a given length; the scheduler grants one requester at a time, runs the counter from 0 to the latched length, then signals completion. It sits between the requester logic and the `up5bit_counter` datapath and owns that counter's sequencing: start, terminal count, abort and reset.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `OW`, default `$clog2(NREQ)`: width of `owner`.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: per-requester request level, held high until `done` or abort.
- `len`  in  5*NREQ: per-requester window length; slice i is `len[5*i+4:5*i]`; sampled at grant.
- `gnt`  out  NREQ: one-hot grant, registered.
- `done`  out  NREQ: one-cycle completion pulse to the owner, registered.
- `cnt`  out  5: shared counter value, registered.
- `owner`  out  OW: index of the current or last owner.
- `busy`  out  1: high when the state is not IDLE.

## Operation
- Reset values: state IDLE; `gnt`=0, `done`=0, `cnt`=0, `owner`=0, `busy`=0; round-robin pointer `ptr`=NREQ-1, so req0 wins first.
- **IDLE**
  - If `req`≠0, choose winner w = the first set bit searching from `ptr`+1 upward with wrap.
  - Next edge: state COUNT, `gnt`=1<<w, `owner`=w, `ptr`=w, `len_q`=len slice w, `cnt`=0.
- **COUNT**, evaluated each edge in this priority order:
  - `req[owner]`=0: abort. Go to IDLE, `gnt`=0, `cnt`=0, no `done`.
  - Else `cnt`==`len_q`: go to DONE, `done[owner]`=1, `cnt` holds.
  - Else `cnt`=`cnt`+1.
- **DONE**
  - Lasts one cycle. Next edge: IDLE, `gnt`=0, `done`=0, `cnt`=0.
- Arithmetic: `cnt` is 5-bit unsigned and never wraps, because counting stops at `len_q` ≤ 31. `len_q`=0 gives a window of one cycle at `cnt`=0.
- Changes on `len` after grant are ignored. `req` changes of non-owners during COUNT or DONE do not affect the running window.
- Requester rule: deassert `req` in the cycle after `done`. A `req` still high in the IDLE cycle is eligible again, but the pointer has already advanced past it.
- Simultaneous requests in IDLE: only the round-robin winner is granted. The others wait with no loss of request.
- `reset` asserted mid-window: all outputs return to reset values immediately (asynchronous), no `done` is issued, and `ptr` returns to NREQ-1.

## Timing
- `req[i]` high while IDLE, sampled at edge k: `gnt[i]` high after k+1 with `cnt`=0.
- `cnt` takes values 0..`len_q` on edges k+1..k+1+`len_q`.
- `done[i]` is high for exactly one cycle, after edge k+`len_q`+2.
- `gnt[i]` drops after edge k+`len_q`+3.
- The next grant appears at edge k+`len_q`+4 at the earliest (one mandatory IDLE cycle).
- Abort: `req[owner]` low sampled at edge m during COUNT → `gnt`=0 and `cnt`=0 after m.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `UP5_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest index wins. `ptr` is unused and is tied so the search always starts at 0.
  - Undefined (default): round-robin as described above.
  - Ports and timing are identical in both builds.

## Test plan
- Reset, then `req`=0001 with len0=3: `gnt`=0001 at edge 1, `cnt` 0,1,2,3, `done[0]` pulse after edge 5, `gnt`=0 after edge 6.
- `req`=1111 held, all `len`=0: grants in order 0,1,2,3,0, each 3 cycles apart. Under `UP5_SCHED_FIXED_PRIO_EN` the grant goes to 0 every time.
- len2=31 with req2 alone: `cnt` reaches 31 with no wrap, `done[2]` after 33 cycles from the request edge.
- Owner 1 with len1=10 drops `req[1]` at `cnt`=4: `gnt`=0 and `cnt`=0 next edge, no `done`; a pending req3 is granted after that.
- `reset` asserted low at `cnt`=7 of a len=20 window: all outputs 0 immediately. After release, `req`=1010 grants requester 1.
- Owner changes `len` mid-window (len0 from 5 to 2): the window still ends at `cnt`=5.
